exe_stage_div: RTL and testbench
================================

Name: exe_stage_div

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between decode and memory.
- Consumes the decode bus and computes the ALU result or the data-memory address.
- Issues the data-SRAM request and hands a 71-bit bus to the memory stage.
- Contains an iterative 32-bit divider, so the stage holds its instruction through a multi-cycle DIV/DIVU/MOD/MODU.

Parameters:
- DIV_CYCLES, 32, number of divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset; all state clears immediately on assertion
- ms_allowin  in  1  memory stage can accept
- es_allowin  out  1  this stage can accept
- ds_to_es_valid  in  1  decode output valid
- ds_to_es_bus  in  139  {alu_op[12], div_en, div_signed, div_rem, load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest[5], imm[16], rs_value[32], rt_value[32], pc[32]}, MSB first
- es_to_ms_valid  out  1  handoff valid
- es_to_ms_bus  out  71  {res_from_mem, gr_we, dest[5], result[32], pc[32]}
- es_fwd_bus  out  39  {es_is_load, gr_we&&es_valid, dest[5], result[32]}
- data_sram_en  out  1  memory request
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  address (ALU sum)
- data_sram_wdata  out  32  rt_value

Behaviour:
- Reset (resetn low):
  - es_valid=0, divider FSM=IDLE, counter=0.
  - es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0.
  - es_fwd_bus valid bit=0.
  - The bus register holds don't-care data.
- Pipeline handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - When es_allowin: es_valid <= ds_to_es_valid.
  - The bus register loads only when ds_to_es_valid && es_allowin.
  - es_to_ms_valid = es_valid && es_ready_go.
- es_ready_go: 1 for non-divide instructions; for div_en it is 1 only in FSM state DONE.
- ALU:
  - Combinational: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
  - src2 = src2_is_imm ? sign-extended imm : src2_is_8 ? 32'd8 : rt_value.
- Divider FSM (IDLE -> BUSY -> DONE -> IDLE):
  - IDLE->BUSY: es_valid && div_en in IDLE. Latch operand magnitudes and signs; counter=0.
  - BUSY: one restoring step per cycle. After DIV_CYCLES steps, go to DONE.
  - Result ready DIV_CYCLES+1 cycles after the instruction enters the stage.
  - DONE: apply sign fix. The quotient is negative iff the operand signs differ; the remainder takes the dividend's sign. result = div_rem ? remainder : quotient.
  - DONE->IDLE: on handoff (es_to_ms_valid && ms_allowin). DONE holds while ms_allowin=0.
- Divide boundary cases:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend. Unsigned rules apply to magnitudes; signed results are then sign-fixed.
  - Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
  - A new instruction never enters while the FSM is BUSY or DONE.
- Reset mid-division: FSM returns to IDLE, the instruction is discarded, and no partial result is forwarded.
- Memory:
  - data_sram_en = es_valid && (load_op || mem_we).
  - data_sram_wen = {4{mem_we && es_valid && ms_allowin}}, so a store is issued exactly once.
  - data_sram_addr = ALU sum.
- res_from_mem = load_op. Result = divider output if div_en, else ALU output.

Optional Feature:
- Macro ES_BYPASS_EN.
- Defined: es_fwd_bus drives the live values. During a BUSY divide its valid bit is 1 and es_is_load=1, so decode stalls dependents rather than consuming the partial result.
- Undefined: es_fwd_bus is constant 0, and decode relies on its own scoreboard stall.

Decomposition:
- Shared header mycpu.h: DS_TO_ES_BUS_WD=139, ES_TO_MS_BUS_WD=71, ES_FWD_BUS_WD=39, ALU op bit indices, divider FSM state encodings.
- One sub-module: div_iter. It owns the FSM, counter and restoring datapath, with ports clk, resetn, start, signed, dividend, divisor, busy, done, ack, quotient, remainder.

Test Plan:
- ADDU rs=5, rt=7, ms_allowin=1 -> the next cycle es_to_ms_valid=1 with result 12; no stall.
- DIVU 100/7, div_rem=0 -> es_allowin=0 for 33 cycles, then handoff with result 14; MODU 100/7 -> 2.
- DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- DIVU 9/0 -> quotient 0xFFFFFFFF, remainder 9; the FSM returns to IDLE after handoff.
- SW with ms_allowin held 0 for 3 cycles -> data_sram_wen=4'hF asserted only in the single cycle ms_allowin=1.
- resetn pulsed low at cycle 10 of a divide -> es_valid=0 and FSM IDLE immediately. The next ADDU completes normally, and no divide result appears.

Source files
------------

// File: rtl/exe_stage_div_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU op bit
// indices, divider FSM encodings and the packed bus payloads.
package exe_stage_div_pkg;

    localparam int unsigned DS_TO_ES_BUS_WD = 139;
    localparam int unsigned ES_TO_MS_BUS_WD = 71;
    localparam int unsigned ES_FWD_BUS_WD   = 39;
    localparam int unsigned ALU_OP_WD       = 12;
    localparam int unsigned DIV_CYCLES_DEF  = 32;

    // One-hot ALU op bit positions inside alu_op
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    // Divider FSM encodings
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 div_en;
        logic                 div_signed;
        logic                 div_rem;
        logic                 load_op;
        logic                 src1_is_sa;
        logic                 src1_is_pc;
        logic                 src2_is_imm;
        logic                 src2_is_8;
        logic                 gr_we;
        logic                 mem_we;
        logic [4:0]           dest;
        logic [15:0]          imm;
        logic [31:0]          rs_value;
        logic [31:0]          rt_value;
        logic [31:0]          pc;
    } ds_to_es_bus_t;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic        es_is_load;
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] result;
    } es_fwd_bus_t;

    // Two's-complement negate when neg is set (magnitude / sign fix helper)
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/exe_stage_div_div_iter.sv
// div_iter: iterative restoring 32-bit divider, one quotient bit per cycle.
//   clk, resetn          clock, async active-low reset
//   start                launch a divide (sampled in IDLE only)
//   signed_op            treat dividend/divisor as two's complement
//   dividend, divisor    operands, sampled on start
//   busy, done           FSM in BUSY / DONE
//   ack                  result consumed; DONE returns to IDLE
//   quotient, remainder  sign-fixed results, stable while done
// Divisor 0 falls out of the restoring loop naturally: every step
// subtracts zero, so the quotient is all ones and the remainder is the
// dividend magnitude.
module div_iter
    import exe_stage_div_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int unsigned          CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic [32:0]      partial;
    logic [32:0]      diff;
    logic             step_ge;
    logic [31:0]      step_rem;
    logic [31:0]      step_quo;

    // One restoring step: shift next dividend bit in, subtract if it fits
    always_comb begin
        partial  = {rem_q, quo_q[31]};
        diff     = partial - {1'b0, dvs_q};
        step_ge  = ~diff[32];
        step_rem = step_ge ? diff[31:0] : partial[31:0];
        step_quo = {quo_q[30:0], step_ge};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = cond_neg32(dividend, signed_op & dividend[31]);
                    dvs_d   = cond_neg32(divisor, signed_op & divisor[31]);
                    q_neg_d = signed_op & (dividend[31] ^ divisor[31]);
                    r_neg_d = signed_op & dividend[31];
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                rem_d = step_rem;
                quo_d = step_quo;
                // Last step: fold the sign fix in so DONE holds final values
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                    quo_d   = cond_neg32(step_quo, q_neg_q);
                    rem_d   = cond_neg32(step_rem, r_neg_q);
                end
            end
            DIV_DONE: begin
                if (ack) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/exe_stage_div.sv
// exe_stage_div: MIPS execute stage with ALU, data-SRAM request and an
// iterative divider that holds the instruction until its result is ready.
//   clk, resetn        clock, async active-low reset
//   ds_to_es_valid/bus decode handoff (139-bit)
//   es_allowin         this stage can accept a new instruction
//   ms_allowin         memory stage can accept
//   es_to_ms_valid/bus handoff to memory (71-bit)
//   es_fwd_bus         forwarding info to decode (39-bit)
//   data_sram_*        data-memory request
// Build option: ES_BYPASS_EN drives live forwarding values on es_fwd_bus;
// without it es_fwd_bus is tied to zero.
module exe_stage_div
    import exe_stage_div_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    logic          es_valid_q, es_valid_d;
    ds_to_es_bus_t bus_q, bus_d;

    logic          es_ready_go;
    logic          div_busy;
    logic          div_done;
    logic          div_start;
    logic          div_ack;
    logic [31:0]   div_quo;
    logic [31:0]   div_rem;

    logic [31:0]   src1;
    logic [31:0]   src2;
    logic [31:0]   alu_sum;
    logic [31:0]   alu_res;
    logic [31:0]   es_result;
    es_to_ms_bus_t ms_bus;

    // Handshake: divides hold the stage until the divider reports DONE
    assign es_ready_go    = !bus_q.div_en || div_done;
    assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go;

    // Valid / bus register next state
    always_comb begin
        es_valid_d = es_valid_q;
        bus_d      = bus_q;
        if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
        end
        if (ds_to_es_valid && es_allowin) begin
            bus_d = ds_to_es_bus_t'(ds_to_es_bus);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
        end
    end

    // Operand selection
    always_comb begin
        if (bus_q.src1_is_sa) begin
            src1 = {27'b0, bus_q.imm[10:6]};
        end else if (bus_q.src1_is_pc) begin
            src1 = bus_q.pc;
        end else begin
            src1 = bus_q.rs_value;
        end
        if (bus_q.src2_is_imm) begin
            src2 = {{16{bus_q.imm[15]}}, bus_q.imm};
        end else if (bus_q.src2_is_8) begin
            src2 = 32'd8;
        end else begin
            src2 = bus_q.rt_value;
        end
    end

    // ALU: one-hot op select, OR of masked results
    always_comb begin
        alu_sum = bus_q.alu_op[ALU_SUB] ? 32'(src1 - src2) : 32'(src1 + src2);
        alu_res = '0;
        if (bus_q.alu_op[ALU_ADD] || bus_q.alu_op[ALU_SUB]) begin
            alu_res = alu_res | alu_sum;
        end
        if (bus_q.alu_op[ALU_SLT]) begin
            alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
        end
        if (bus_q.alu_op[ALU_SLTU]) begin
            alu_res = alu_res | {31'b0, src1 < src2};
        end
        if (bus_q.alu_op[ALU_AND]) begin
            alu_res = alu_res | (src1 & src2);
        end
        if (bus_q.alu_op[ALU_NOR]) begin
            alu_res = alu_res | ~(src1 | src2);
        end
        if (bus_q.alu_op[ALU_OR]) begin
            alu_res = alu_res | (src1 | src2);
        end
        if (bus_q.alu_op[ALU_XOR]) begin
            alu_res = alu_res | (src1 ^ src2);
        end
        if (bus_q.alu_op[ALU_SLL]) begin
            alu_res = alu_res | (src2 << src1[4:0]);
        end
        if (bus_q.alu_op[ALU_SRL]) begin
            alu_res = alu_res | (src2 >> src1[4:0]);
        end
        if (bus_q.alu_op[ALU_SRA]) begin
            alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
        end
        if (bus_q.alu_op[ALU_LUI]) begin
            alu_res = alu_res | {src2[15:0], 16'b0};
        end
    end

    // Divider launches only from an idle divider with a live divide in stage
    assign div_start = es_valid_q && bus_q.div_en && !div_busy && !div_done;
    assign div_ack   = es_to_ms_valid && ms_allowin;

    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (bus_q.div_signed),
        .dividend  (bus_q.rs_value),
        .divisor   (bus_q.rt_value),
        .busy      (div_busy),
        .done      (div_done),
        .ack       (div_ack),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign es_result = bus_q.div_en ? (bus_q.div_rem ? div_rem : div_quo) : alu_res;

    // Memory-stage payload
    always_comb begin
        ms_bus              = '0;
        ms_bus.res_from_mem = bus_q.load_op;
        ms_bus.gr_we        = bus_q.gr_we;
        ms_bus.dest         = bus_q.dest;
        ms_bus.result       = es_result;
        ms_bus.pc           = bus_q.pc;
    end
    assign es_to_ms_bus = ms_bus;

    // Store enables gated by ms_allowin so a held store is issued once
    assign data_sram_en    = es_valid_q && (bus_q.load_op || bus_q.mem_we);
    assign data_sram_wen   = {4{bus_q.mem_we && es_valid_q && ms_allowin}};
    assign data_sram_addr  = alu_sum;
    assign data_sram_wdata = bus_q.rt_value;

`ifdef ES_BYPASS_EN
    // An unfinished divide masquerades as a load so decode stalls dependents
    es_fwd_bus_t fwd;
    always_comb begin
        fwd            = '0;
        fwd.es_is_load = bus_q.load_op || (bus_q.div_en && !div_done);
        fwd.valid      = bus_q.gr_we && es_valid_q;
        fwd.dest       = bus_q.dest;
        fwd.result     = es_result;
    end
    assign es_fwd_bus = fwd;
`else
    assign es_fwd_bus = '0;
`endif

endmodule

// File: tb/tb_exe_stage_div.sv
// Self-checking bench for exe_stage_div: table of single-cycle ALU/memory
// vectors followed by directed multi-cycle divide, store and reset sequences.
module tb_exe_stage_div;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ms_allowin = 1'b1;
    logic         es_allowin;
    logic         ds_to_es_valid = 1'b0;
    logic [138:0] ds_to_es_bus = '0;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [38:0]  es_fwd_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks = 0;
    int failures = 0;

    exe_stage_div dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_fwd_bus      (es_fwd_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    // {div_en, div_signed, div_rem, load_op, src1_is_sa, src1_is_pc,
    //  src2_is_imm, src2_is_8, gr_we, mem_we}
    localparam logic [9:0] F_DIV  = 10'h200;
    localparam logic [9:0] F_SGN  = 10'h100;
    localparam logic [9:0] F_REM  = 10'h080;
    localparam logic [9:0] F_LOAD = 10'h040;
    localparam logic [9:0] F_SA   = 10'h020;
    localparam logic [9:0] F_PC   = 10'h010;
    localparam logic [9:0] F_IMM  = 10'h008;
    localparam logic [9:0] F_8    = 10'h004;
    localparam logic [9:0] F_WE   = 10'h002;
    localparam logic [9:0] F_MEM  = 10'h001;

    typedef struct {
        string       name;
        logic [11:0] op;
        logic [9:0]  flags;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] exp_res;
        logic        exp_en;
        logic [3:0]  exp_wen;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [138:0] mk_bus(input logic [11:0] op, input logic [9:0] flags,
                                            input logic [15:0] imm, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [31:0] pc);
        return {op, flags, 5'd3, imm, rs, rt, pc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_fwd_idle_div(input string nm);
`ifdef ES_BYPASS_EN
        chk({nm, "_fwd_load_valid"}, 32'(es_fwd_bus[38:37]), 32'd3);
        chk({nm, "_fwd_dest"}, 32'(es_fwd_bus[36:32]), 32'd3);
`else
        chk({nm, "_fwd_hi"}, 32'(es_fwd_bus[38:32]), 32'd0);
        chk({nm, "_fwd_lo"}, es_fwd_bus[31:0], 32'd0);
`endif
    endtask

    // Divide with an ADDU (1+2) waiting behind it for the whole divide
    task automatic run_div(input string nm, input logic sgn, input logic rem,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int   stall;
        bit   got;
        logic [9:0] f;
        stall = 0;
        got   = 1'b0;
        f = F_DIV | F_WE | (sgn ? F_SGN : 10'h0) | (rem ? F_REM : 10'h0);
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_bus(12'h0, f, 16'h0, a, b, 32'hBFC01000);
        @(negedge clk);
        ds_to_es_bus   = mk_bus(OP_ADD, F_WE, 16'h0, 32'd1, 32'd2, 32'hBFC01004);
        for (int c = 0; c < 60 && !got; c++) begin
            if (c > 0) @(negedge clk);
            if (es_to_ms_valid) got = 1'b1;
            else if (!es_allowin) stall++;
            if (c == 5) chk_fwd_idle_div(nm);
        end
        chk({nm, "_handoff_seen"}, 32'(got), 32'd1);
        chk({nm, "_stall_cycles"}, 32'(stall), 32'd33);
        chk({nm, "_result"}, es_to_ms_bus[63:32], exp);
        chk({nm, "_pc"}, es_to_ms_bus[31:0], 32'hBFC01000);
        chk({nm, "_allowin_at_done"}, 32'(es_allowin), 32'd1);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        chk({nm, "_next_valid"}, 32'(es_to_ms_valid), 32'd1);
        chk({nm, "_next_result"}, es_to_ms_bus[63:32], 32'd3);
        chk({nm, "_next_pc"}, es_to_ms_bus[31:0], 32'hBFC01004);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   wen_cycles;
        int   seen;
        bit   got;

        vecs[0]  = '{"addu",  OP_ADD,  F_WE,        32'd5,        32'd7,        16'h0000, 32'hBFC00000, 32'd12,       1'b0, 4'h0};
        vecs[1]  = '{"subu",  OP_SUB,  F_WE,        32'd5,        32'd7,        16'h0000, 32'hBFC00004, 32'hFFFFFFFE, 1'b0, 4'h0};
        vecs[2]  = '{"slt",   OP_SLT,  F_WE,        32'hFFFFFFFF, 32'd1,        16'h0000, 32'hBFC00008, 32'd1,        1'b0, 4'h0};
        vecs[3]  = '{"sltu",  OP_SLTU, F_WE,        32'hFFFFFFFF, 32'd1,        16'h0000, 32'hBFC0000C, 32'd0,        1'b0, 4'h0};
        vecs[4]  = '{"and",   OP_AND,  F_WE,        32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 32'hBFC00010, 32'h00F000F0, 1'b0, 4'h0};
        vecs[5]  = '{"nor",   OP_NOR,  F_WE,        32'h12345678, 32'h00000000, 16'h0000, 32'hBFC00014, 32'hEDCBA987, 1'b0, 4'h0};
        vecs[6]  = '{"or",    OP_OR,   F_WE,        32'hF000000F, 32'h0F0000F0, 16'h0000, 32'hBFC00018, 32'hFF0000FF, 1'b0, 4'h0};
        vecs[7]  = '{"xor",   OP_XOR,  F_WE,        32'hFF00FF00, 32'h0FF00FF0, 16'h0000, 32'hBFC0001C, 32'hF0F0F0F0, 1'b0, 4'h0};
        vecs[8]  = '{"sll",   OP_SLL,  F_SA|F_WE,   32'h0000DEAD, 32'h00000001, 16'h0100, 32'hBFC00020, 32'h00000010, 1'b0, 4'h0};
        vecs[9]  = '{"srl",   OP_SRL,  F_SA|F_WE,   32'h0000DEAD, 32'h80000000, 16'h0100, 32'hBFC00024, 32'h08000000, 1'b0, 4'h0};
        vecs[10] = '{"sra",   OP_SRA,  F_SA|F_WE,   32'h0000DEAD, 32'h80000000, 16'h0100, 32'hBFC00028, 32'hF8000000, 1'b0, 4'h0};
        vecs[11] = '{"lui",   OP_LUI,  F_IMM|F_WE,  32'h00000055, 32'h00000000, 16'h1234, 32'hBFC0002C, 32'h12340000, 1'b0, 4'h0};
        vecs[12] = '{"addiu", OP_ADD,  F_IMM|F_WE,  32'd10,       32'd0,        16'hFFFF, 32'hBFC00030, 32'd9,        1'b0, 4'h0};
        vecs[13] = '{"jal",   OP_ADD,  F_PC|F_8|F_WE, 32'h0,      32'h0,        16'h0000, 32'hBFC00010, 32'hBFC00018, 1'b0, 4'h0};
        vecs[14] = '{"lw",    OP_ADD,  F_LOAD|F_IMM|F_WE, 32'h1000, 32'h0,      16'h0010, 32'hBFC00038, 32'h00001010, 1'b1, 4'h0};
        vecs[15] = '{"sw",    OP_ADD,  F_MEM|F_IMM, 32'h2000,     32'hCAFEF00D, 16'hFFFC, 32'hBFC0003C, 32'h00001FFC, 1'b1, 4'hF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        chk("rst_es_allowin", 32'(es_allowin), 32'd1);
        chk("rst_sram_en", 32'(data_sram_en), 32'd0);
        chk("rst_sram_wen", 32'(data_sram_wen), 32'd0);
        chk("rst_fwd_valid", 32'(es_fwd_bus[37]), 32'd0);
        resetn = 1'b1;

        // Single-cycle ALU / memory vectors
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ms_allowin     = 1'b1;
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = mk_bus(vecs[i].op, vecs[i].flags, vecs[i].imm,
                                    vecs[i].rs, vecs[i].rt, vecs[i].pc);
            @(negedge clk);
            ds_to_es_valid = 1'b0;
            chk({vecs[i].name, "_valid"}, 32'(es_to_ms_valid), 32'd1);
            chk({vecs[i].name, "_allowin"}, 32'(es_allowin), 32'd1);
            chk({vecs[i].name, "_result"}, es_to_ms_bus[63:32], vecs[i].exp_res);
            chk({vecs[i].name, "_pc"}, es_to_ms_bus[31:0], vecs[i].pc);
            chk({vecs[i].name, "_mem_we_dest"}, 32'(es_to_ms_bus[70:64]),
                32'({vecs[i].flags[6], vecs[i].flags[1], 5'd3}));
            chk({vecs[i].name, "_sram_en"}, 32'(data_sram_en), 32'(vecs[i].exp_en));
            chk({vecs[i].name, "_sram_wen"}, 32'(data_sram_wen), 32'(vecs[i].exp_wen));
            if (vecs[i].exp_en) begin
                chk({vecs[i].name, "_sram_addr"}, data_sram_addr, vecs[i].exp_res);
                chk({vecs[i].name, "_sram_wdata"}, data_sram_wdata, vecs[i].rt);
            end
`ifdef ES_BYPASS_EN
            chk({vecs[i].name, "_fwd"}, 32'(es_fwd_bus[38:32]),
                32'({vecs[i].flags[6], vecs[i].flags[1], 5'd3}));
`else
            chk({vecs[i].name, "_fwd"}, 32'(es_fwd_bus[38:32]), 32'd0);
`endif
        end

        // Divides, including divisor-zero and overflow corners
        run_div("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        run_div("modu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2);
        run_div("div_m7_2",   1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("mod_m7_2",   1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("div_ovf",    1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("mod_ovf",    1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_div("divu_9_0",   1'b0, 1'b0, 32'd9, 32'd0, 32'hFFFFFFFF);
        run_div("modu_9_0",   1'b0, 1'b1, 32'd9, 32'd0, 32'd9);

        // DONE holds the result while memory stage is blocked
        @(negedge clk);
        ms_allowin     = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_bus(12'h0, F_DIV|F_WE, 16'h0, 32'd100, 32'd7, 32'hBFC02000);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (c > 0) @(negedge clk);
            if (es_to_ms_valid) got = 1'b1;
        end
        chk("hold_done_seen", 32'(got), 32'd1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk("hold_valid", 32'(es_to_ms_valid), 32'd1);
            chk("hold_result", es_to_ms_bus[63:32], 32'd14);
            chk("hold_allowin", 32'(es_allowin), 32'd0);
        end
        ms_allowin = 1'b1;
        #1;
        chk("hold_release_allowin", 32'(es_allowin), 32'd1);
        @(negedge clk);
        chk("hold_after_valid", 32'(es_to_ms_valid), 32'd0);

        // Store blocked by ms_allowin: write enable only in the accepting cycle
        @(negedge clk);
        ms_allowin     = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_bus(OP_ADD, F_MEM|F_IMM, 16'h0004, 32'h100, 32'hDEADBEEF, 32'hBFC03000);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        wen_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (data_sram_wen != 4'h0) wen_cycles++;
            chk("sw_hold_en", 32'(data_sram_en), 32'd1);
            chk("sw_hold_allowin", 32'(es_allowin), 32'd0);
        end
        chk("sw_addr", data_sram_addr, 32'h104);
        chk("sw_wdata", data_sram_wdata, 32'hDEADBEEF);
        ms_allowin = 1'b1;
        #1;
        if (data_sram_wen != 4'h0) wen_cycles++;
        chk("sw_release_wen", 32'(data_sram_wen), 32'hF);
        @(negedge clk);
        if (data_sram_wen != 4'h0) wen_cycles++;
        chk("sw_after_en", 32'(data_sram_en), 32'd0);
        chk("sw_wen_cycles", 32'(wen_cycles), 32'd1);

        // Reset in the middle of a divide
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_bus(12'h0, F_DIV|F_WE, 16'h0, 32'd100, 32'd7, 32'hBFC04000);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(es_to_ms_valid), 32'd0);
        chk("midrst_allowin", 32'(es_allowin), 32'd1);
        chk("midrst_sram_en", 32'(data_sram_en), 32'd0);
        chk("midrst_fwd_valid", 32'(es_fwd_bus[37]), 32'd0);
        @(negedge clk);
        resetn         = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk_bus(OP_ADD, F_WE, 16'h0, 32'd20, 32'd22, 32'hBFC04004);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        chk("midrst_addu_valid", 32'(es_to_ms_valid), 32'd1);
        chk("midrst_addu_result", es_to_ms_bus[63:32], 32'd42);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (es_to_ms_valid) seen++;
        end
        chk("midrst_no_div_result", 32'(seen), 32'd0);
        run_div("post_rst_divu", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
